window_gen_3x3: RTL and testbench
=================================

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter IMG_W, default 16, pixels per row (min 3).
REQ-002 SHALL have parameter IMG_H, default 16, rows per frame (min 3).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port pix_valid  input  1  upstream pixel strobe.
REQ-006 SHALL have port pix_in  input  4  raster-order pixel, row 0 col 0 first.
REQ-007 SHALL have port pix_ready  output  1  block can accept a pixel this cycle.
REQ-008 SHALL have port window_out  output  36  packed 3x3 window for the convolution stage.
REQ-009 SHALL have port wr_sig  output  1  one-cycle strobe; window_out valid while high.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-011 SHALL accept a pixel only on a cycle with pix_valid=1 and pix_ready=1; otherwise no state changes.
REQ-012 SHALL hold col counter (0..IMG_W-1) and row counter (0..IMG_H-1); each accept increments col; col IMG_W-1 wraps to 0 and increments row.
REQ-013 SHALL keep two line buffers of IMG_W x 4 bits holding the previous two rows, plus a 3x3 register window shifted one column per accept.
REQ-014 SHALL pack window_out[4k+3:4k] = pixel at window position k = 3*r+c, r=0 top (oldest row), c=0 left (oldest column); [3:0] top-left, [35:32] bottom-right (newest pixel).
REQ-015 SHALL emit a window (wr_sig=1, registered, one cycle after the accept) only when the accepted pixel has row>=2 and col>=2; no padding, (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-016 SHALL never emit a window mixing pixels across a row wrap (guaranteed by col>=2 rule).
REQ-017 SHALL hold window_out at its last value when wr_sig=0.
REQ-018 SHALL implement FSM states IDLE, ACTIVE, DONE.
REQ-019 IDLE: pix_ready=1; first accept -> ACTIVE (that pixel is row 0 col 0).
REQ-020 ACTIVE: pix_ready=1; accept of row IMG_H-1 col IMG_W-1 -> DONE; gaps in pix_valid hold state indefinitely.
REQ-021 DONE: lasts exactly one cycle; pix_ready=0 (pix_valid ignored); frame_done=1; counters cleared; -> IDLE.
REQ-022 frame_done SHALL coincide with the final wr_sig of the frame.
REQ-023 Line buffer contents SHALL NOT need clearing between frames; first two rows of a new frame overwrite them before any window is emitted.
REQ-024 Throughput SHALL be one pixel per cycle sustained, except the single DONE cycle per frame.

Reset
REQ-025 While reset=0 at a clock edge: state=IDLE, row=col=0, pix_ready=0, wr_sig=0, frame_done=0, window_out=0.
REQ-026 First cycle after reset release SHALL show pix_ready=1.
REQ-027 Reset mid-frame SHALL abandon the frame; the next accepted pixel after release is treated as row 0 col 0; no stale window SHALL be emitted.

Verification (IMG_W=4, IMG_H=4 unless stated; pixel n value = n mod 16)
REQ-028 Stream pixels 0..15 back-to-back -> wr_sig exactly 4 times, one cycle after accepts of indices 10,11,14,15; first window_out = 36'hA98654210; second = 36'hBA9765321.
REQ-029 Same stream -> frame_done=1 for one cycle coincident with 4th wr_sig; pix_ready=0 that cycle; pix_ready=1 next cycle; second frame yields identical 4 windows.
REQ-030 Same stream with pix_valid toggling 1/0 each cycle -> same 4 windows/values, wr_sig only one cycle after a valid accept, never during gaps.
REQ-031 All pixels 4'hF, IMG_W=IMG_H=16 -> 196 wr_sig pulses, each window_out = 36'hFFFFFFFFF.
REQ-032 Assert reset=0 for one cycle after pixel 9 of frame 1, then stream 0..15 -> no wr_sig before new index 10; windows equal REQ-028 values.
REQ-033 Assert pix_valid=1 during the DONE cycle with pix_in=4'h7 -> pixel not accepted; next frame's row 0 col 0 comes from the following accepted pixel.

Source files
------------

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator for a raster pixel stream.
// Two line buffers plus a 3x3 register window feed a convolution stage.
module window_gen_3x3 #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic [3:0]  pix_in,
    output logic        pix_ready,
    output logic [35:0] window_out,
    output logic        wr_sig,
    output logic        frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [3:0]    line_top [IMG_W];
    logic [3:0]    line_mid [IMG_W];
    logic [3:0]    win      [9];
    logic [3:0]    win_nxt  [9];
    logic [35:0]   win_packed;
    logic          accept;
    logic          last_pix;
    logic          emit;

    assign accept   = pix_valid && pix_ready;
    assign last_pix = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));

    // Frame-level control: ready gating, end-of-frame pulse, next state.
    always_comb begin
        state_nxt  = state;
        pix_ready  = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                pix_ready = reset;
                if (accept) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                pix_ready = reset;
                if (accept && last_pix) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (!reset || state == DONE) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                if (row == RW'(IMG_H - 1)) row <= '0;
                else                       row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Next window: shift one column left, new right column from buffers.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nxt[3*r]   = win[3*r+1];
            win_nxt[3*r+1] = win[3*r+2];
        end
        win_nxt[2] = line_top[col];
        win_nxt[5] = line_mid[col];
        win_nxt[8] = pix_in;
        win_packed = '0;
        for (int k = 0; k < 9; k++) win_packed[4*k +: 4] = win_nxt[k];
    end

    // Line buffers and window shift; stale contents are never emitted.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_top[col] <= line_mid[col];
            line_mid[col] <= pix_in;
            win           <= win_nxt;
        end
    end

    // Registered window output, held between strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_sig     <= 1'b0;
            window_out <= '0;
        end else begin
            wr_sig <= emit;
            if (emit) window_out <= win_packed;
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3.
// Image-array reference model, directed and randomized streams.
module tb_window_gen_3x3;
    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        pix_valid;
    logic [3:0]  pix_in;
    logic        pix_ready;
    logic [35:0] window_out;
    logic        wr_sig;
    logic        frame_done;

    logic        v16;
    logic [3:0]  p16;
    logic        rdy16;
    logic [35:0] win16;
    logic        wr16;
    logic        fd16;

    int n_chk  = 0;
    int n_fail = 0;

    int          m_n    = 0;
    bit          m_done = 1'b0;
    logic [3:0]  img [W*H];
    logic        exp_wr  = 1'b0;
    logic        exp_fd  = 1'b0;
    logic [35:0] exp_win = '0;
    logic [35:0] got [$];

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) u4 (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .pix_ready  (pix_ready),
        .window_out (window_out),
        .wr_sig     (wr_sig),
        .frame_done (frame_done)
    );

    window_gen_3x3 #(.IMG_W(16), .IMG_H(16)) u16 (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (v16),
        .pix_in     (p16),
        .pix_ready  (rdy16),
        .window_out (win16),
        .wr_sig     (wr16),
        .frame_done (fd16)
    );

    task automatic chk(input string tag, input logic [35:0] obs,
                       input logic [35:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Window whose bottom-right pixel is frame index n.
    function automatic logic [35:0] build(input int n);
        int r0;
        int c0;
        logic [35:0] w;
        r0 = n / W - 2;
        c0 = n % W - 2;
        w  = '0;
        for (int k = 0; k < 9; k++)
            w[4*k +: 4] = img[(r0 + k / 3) * W + c0 + k % 3];
        return w;
    endfunction

    task automatic step(input logic rst, input logic v, input logic [3:0] p);
        logic rdy;
        reset     = rst;
        pix_valid = v;
        pix_in    = p;
        #2;
        rdy = rst && !m_done;
        chk("pix_ready", {35'd0, pix_ready}, {35'd0, rdy});
        @(posedge clk);
        if (!rst) begin
            m_n     = 0;
            m_done  = 1'b0;
            exp_wr  = 1'b0;
            exp_fd  = 1'b0;
            exp_win = '0;
        end else if (m_done) begin
            m_done = 1'b0;
            exp_wr = 1'b0;
            exp_fd = 1'b0;
        end else if (v) begin
            img[m_n] = p;
            exp_wr   = (m_n / W >= 2) && (m_n % W >= 2);
            if (exp_wr) exp_win = build(m_n);
            exp_fd   = (m_n == W * H - 1);
            m_done   = exp_fd;
            m_n      = exp_fd ? 0 : m_n + 1;
        end else begin
            exp_wr = 1'b0;
            exp_fd = 1'b0;
        end
        #1;
        chk("wr_sig", {35'd0, wr_sig}, {35'd0, exp_wr});
        chk("frame_done", {35'd0, frame_done}, {35'd0, exp_fd});
        chk("window_out", window_out, exp_win);
        if (wr_sig) got.push_back(window_out);
    endtask

    task automatic frame(input bit gap);
        for (int n = 0; n < W * H; n++) begin
            step(1'b1, 1'b1, 4'(n));
            if (gap) step(1'b1, 1'b0, 4'($urandom));
        end
    endtask

    task automatic chk_std(input string tag);
        chk({tag, "_count"}, 36'(got.size()), 36'd4);
        chk({tag, "_win0"}, got[0], 36'hA98654210);
        chk({tag, "_win1"}, got[1], 36'hBA9765321);
    endtask

    initial begin
        int acc;
        int guard;
        int cnt;
        int fdc;
        logic v;
        v16 = 1'b0;
        p16 = 4'h0;

        step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h3);
        step(1'b1, 1'b0, 4'h0);

        got.delete();
        frame(1'b0);
        chk_std("f1");

        step(1'b1, 1'b1, 4'h7);
        got.delete();
        frame(1'b0);
        chk_std("f2");
        step(1'b1, 1'b0, 4'h0);

        got.delete();
        frame(1'b1);
        chk_std("gap");

        for (int n = 0; n < 10; n++) step(1'b1, 1'b1, 4'(n));
        step(1'b0, 1'b0, 4'h0);
        got.delete();
        frame(1'b0);
        chk_std("rst");
        step(1'b1, 1'b0, 4'h0);

        for (int f = 0; f < 3; f++) begin
            acc   = 0;
            guard = 0;
            got.delete();
            while (acc < W * H && guard < 400) begin
                v = ($urandom_range(0, 3) != 0);
                if (v && !m_done) acc++;
                step(1'b1, v, 4'($urandom));
                guard++;
            end
            chk("rnd_count", 36'(got.size()), 36'd4);
        end
        step(1'b1, 1'b0, 4'h0);

        pix_valid = 1'b0;
        cnt = 0;
        fdc = 0;
        for (int i = 0; i < 260; i++) begin
            v16 = (i < 256);
            p16 = 4'hF;
            @(posedge clk);
            #1;
            if (wr16) begin
                cnt++;
                chk("w16_win", win16, 36'hFFFFFFFFF);
            end
            if (fd16) fdc++;
        end
        chk("w16_count", 36'(cnt), 36'd196);
        chk("w16_fd", 36'(fdc), 36'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
